// File: rtl/fir_frame_rx.sv
// fir_frame_rx: receive-side framer for the FIR output stream.
// Packs the free-running FIR sample stream into FRAME_LEN-sample frames held
// in a two-bank ping-pong buffer and replays completed frames over a
// valid/ready handshake. Samples arriving while the target bank is full are
// dropped and flagged via the sticky overflow output.
// Optional feature macro: FIR_FRAME_RX_DROP_CNT_EN builds the 16-bit
// saturating dropped-sample counter; otherwise drop_cnt is tied to zero.
module fir_frame_rx #(
    parameter int FRAME_LEN = 16,
    parameter int IDXW      = 4,
    parameter int DW        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fir_valid,
    input  logic [DW-1:0]   fir_d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            overflow,
    output logic [15:0]     drop_cnt
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

    logic [DW-1:0]   mem_q [2][FRAME_LEN];
    logic [1:0]      full_q,    full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IDXW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [IDXW-1:0] rd_idx_q,  rd_idx_d;
    logic            overflow_q, overflow_d;
    logic            store, drop, xfer;

    // Next-state for write/read pointers, bank selects and full flags.
    // Full flags are only set on a not-full write bank and only cleared on a
    // full read bank, so the two updates never touch the same bank.
    always_comb begin
        store      = fir_valid && !full_q[wr_bank_q];
        drop       = fir_valid &&  full_q[wr_bank_q];
        xfer       = full_q[rd_bank_q] && out_ready;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        overflow_d = overflow_q | drop;

        if (store) begin
            if (wr_ptr_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + IDXW'(1);
            end
        end else if (!fir_valid) begin
            // A gap in the stream abandons any partial frame.
            wr_ptr_d = '0;
        end

        if (xfer) begin
            if (rd_idx_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_idx_d          = '0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + IDXW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage: zero-filled on reset, one write per accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (store) begin
            mem_q[wr_bank_q][wr_ptr_q] <= fir_d;
        end
    end

`ifdef FIR_FRAME_RX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped samples.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem_q[rd_bank_q][rd_idx_q];
    assign out_idx   = rd_idx_q;
    assign out_last  = (rd_idx_q == LAST_IDX);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_frame_rx.sv
// Scoreboard bench for fir_frame_rx: the driver applies stimulus and updates a
// frame-level reference model, pushing every expected output sample into a
// queue; an independent monitor compares DUT outputs against that queue.
module tb_fir_frame_rx;

    localparam int L = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fir_valid = 1'b0;
    logic [15:0] fir_d = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        overflow;
    logic [15:0] drop_cnt;

    fir_frame_rx #(.FRAME_LEN(L), .IDXW(4), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] part[$];
    int          pending = 0;
    int          rdpos   = 0;
    int          drops   = 0;
    int          total   = 0;
    int          bad     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop_cnt();
`ifdef FIR_FRAME_RX_DROP_CNT_EN
        return (drops > 65535) ? 32'd65535 : 32'(drops);
`else
        return 32'd0;
`endif
    endfunction

    // Reference model: a frame completes after L consecutive accepted
    // samples; at most two complete frames can be pending; a frame leaves
    // after L accepted reads. Drop decision uses the pending count before
    // this edge's read takes effect.
    task automatic model_edge(input logic v, input logic [15:0] d, input logic r);
        bit was_full;
        bit dec;
        was_full = (pending == 2);
        dec = 0;
        if (r && pending > 0) begin
            rdpos++;
            if (rdpos == L) begin
                rdpos = 0;
                dec = 1;
            end
        end
        if (v) begin
            if (was_full) begin
                drops++;
            end else begin
                part.push_back(d);
                if (part.size() == L) begin
                    for (int k = 0; k < L; k++) begin
                        exp_t e;
                        e.data = part[k];
                        e.idx  = 4'(k);
                        e.last = (k == L - 1);
                        expq.push_back(e);
                    end
                    part.delete();
                    pending++;
                end
            end
        end else begin
            part.delete();
        end
        if (dec) pending--;
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic r);
        fir_valid = v;
        fir_d     = d;
        out_ready = r;
        @(posedge clk);
        #1;
        if (!rst) model_edge(v, d, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pending = 0;
        rdpos   = 0;
        drops   = 0;
        part.delete();
        expq.delete();
        cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 300) begin
            cyc(1'b0, 16'h0, 1'b1);
            n++;
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: compares outputs at the falling edge, away from input changes.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_data",  {16'b0, out_data},  32'd0);
            chk("rst_idx",   {28'b0, out_idx},   32'd0);
            chk("rst_last",  {31'b0, out_last},  32'd0);
            chk("rst_ovf",   {31'b0, overflow},  32'd0);
            chk("rst_dcnt",  {16'b0, drop_cnt},  32'd0);
        end else begin
            chk("valid",    {31'b0, out_valid}, {31'b0, expq.size() > 0});
            chk("overflow", {31'b0, overflow},  {31'b0, drops > 0});
            chk("drop_cnt", {16'b0, drop_cnt},  exp_drop_cnt());
            if (out_valid && expq.size() > 0) begin
                chk("data", {16'b0, out_data}, {16'b0, expq[0].data});
                chk("idx",  {28'b0, out_idx},  {28'b0, expq[0].idx});
                chk("last", {31'b0, out_last}, {31'b0, expq[0].last});
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        repeat (2) cyc(1'b0, 16'h0, 1'b1);

        // Single frame 1..16, consumer always ready.
        for (int i = 1; i <= L; i++) cyc(1'b1, 16'(i), 1'b1);
        drain();

        // Overflow: 48 samples with consumer stalled, then read out.
        for (int i = 1; i <= 3 * L; i++) cyc(1'b1, 16'(i), 1'b0);
        chk("ovf_drops", 32'(drops), 32'd16);
        drain();

        // Flush: 5 samples, gap, then 100..115.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(50 + i), 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < L; i++) cyc(1'b1, 16'(100 + i), 1'b1);
        drain();

        // Back-pressure: ready pattern 1,0,0 repeating.
        for (int i = 0; i < L; i++) cyc(1'b1, 16'(16'h0300 + i), (i % 3) == 0);
        for (int i = 0; i < 3 * L && expq.size() > 0; i++) cyc(1'b0, 16'h0, (i % 3) == 0);
        drain();

        // Freed-bank race: both banks full, last read of the older bank
        // coincides with an incoming sample.
        for (int i = 0; i < 2 * L; i++) cyc(1'b1, 16'(16'h0400 + i), 1'b0);
        for (int i = 0; i < L - 1; i++) cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < L; i++) cyc(1'b1, 16'(16'h0A00 + i), 1'b1);
        drain();

        // Randomized streaming with random back-pressure.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 15) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset mid-stream, then a fresh frame.
        for (int i = 0; i < L + 7; i++) cyc(1'b1, 16'(16'h0700 + i), 1'b0);
        do_reset();
        for (int i = 0; i < L; i++) cyc(1'b1, 16'(200 + i), 1'b1);
        drain();
        repeat (2) cyc(1'b0, 16'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
